// File: rtl/seq_gen_serial.sv
// ============================================================================
// Module   : seq_gen_serial
// Brief    : Bit-serial pattern transmitter (MSB first, repeated, zero gaps).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_gen_serial #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] rep_count,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [PAT_W-1:0] pat_q,    pat_d;
    logic [PAT_W-1:0] sr_q,     sr_d;
    logic [CNT_W-1:0] rem_q,    rem_d;
    logic [GAP_W-1:0] gap_q,    gap_d;
    logic [GAP_W-1:0] gcnt_q,   gcnt_d;
    logic [BW-1:0]    bcnt_q,   bcnt_d;
    logic             bit_q,    bit_d;
    logic             valid_q,  valid_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [PAT_W-1:0] sr_shift;

    // The MSB of sr_q is always the bit currently on out_bit.
    assign sr_shift = sr_q << 1;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sr_d    = sr_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        bcnt_d  = bcnt_q;
        bit_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    pat_d  = pattern;
                    sr_d   = pattern;
                    rem_d  = rep_count;
                    gap_d  = gap_len;
                    gcnt_d = '0;
                    bcnt_d = '0;
                    busy_d = 1'b1;
                    if (rep_count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SEND;
                        valid_d = 1'b1;
                        bit_d   = pattern[PAT_W-1];
                    end
                end
            end
            SEND: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                if (bcnt_q != LAST_BIT) begin
                    sr_d   = sr_shift;
                    bcnt_d = bcnt_q + BW'(1);
                    bit_d  = sr_shift[PAT_W-1];
                end else begin
                    rem_d  = rem_q - CNT_W'(1);
                    bcnt_d = '0;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (gap_q != '0) begin
                        state_d = GAP;
                        gcnt_d  = GAP_W'(1);
                    end else begin
                        sr_d  = pat_q;
                        bit_d = pat_q[PAT_W-1];
                    end
                end
            end
            GAP: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                if (gcnt_q == gap_q) begin
                    state_d = SEND;
                    sr_d    = pat_q;
                    bit_d   = pat_q[PAT_W-1];
                end else begin
                    gcnt_d = gcnt_q + GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cancel overrides every transition; all outputs drop together.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            bit_d   = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            sr_q    <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            bcnt_q  <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sr_q    <= sr_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            bcnt_q  <= bcnt_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_bit   = bit_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_gen_serial.sv
// ============================================================================
// Module   : tb_seq_gen_serial
// Brief    : Randomized self-checking bench for seq_gen_serial.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_gen_serial;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
    localparam int GAP_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] rep_count;
    logic [GAP_W-1:0] gap_len;
    logic             abort;
    logic             out_bit;
    logic             out_valid;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    // Expected per-cycle output tuple {out_valid, out_bit, busy, done}.
    logic [3:0] exp_q[$];

    seq_gen_serial #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .rep_count (rep_count),
        .gap_len   (gap_len),
        .abort     (abort),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] obs();
        return {out_valid, out_bit, busy, done};
    endfunction

    // Reference stream: each repetition's bits MSB first, zero gaps between
    // repetitions only, then one done cycle.
    task automatic build(input logic [PAT_W-1:0] pat, input int rep, input int gap);
        exp_q.delete();
        for (int r = 0; r < rep; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                exp_q.push_back({1'b1, pat[b], 1'b1, 1'b0});
            if (r < rep - 1)
                for (int g = 0; g < gap; g++)
                    exp_q.push_back(4'b1010);
        end
        exp_q.push_back(4'b0011);
    endtask

    task automatic noise();
        start     = 1'($urandom_range(0, 1));
        pattern   = PAT_W'($urandom);
        rep_count = CNT_W'($urandom);
        gap_len   = GAP_W'($urandom);
    endtask

    // Called at posedge+1; abort_at < 0 means run to completion.
    task automatic run(input string tag, input logic [PAT_W-1:0] pat, input int rep,
                       input int gap, input int abort_at);
        int  busy_cnt;
        bit  aborted;
        busy_cnt  = 0;
        aborted   = 0;
        pattern   = pat;
        rep_count = CNT_W'(rep);
        gap_len   = GAP_W'(gap);
        start     = 1'b1;
        build(pat, rep, gap);
        for (int i = 0; i < exp_q.size() && !aborted; i++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("%s[%0d]", tag, i), 32'(obs()), 32'(exp_q[i]));
            busy_cnt += int'(busy);
            if (i == abort_at) begin
                start   = 1'b0;
                abort   = 1'b1;
                aborted = 1;
            end else if (i != exp_q.size() - 1) begin
                noise();
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_val($sformatf("%s_after", tag), 32'(obs()), 32'h0);
        if (aborted) begin
            @(posedge clk);
            #1;
            check_val($sformatf("%s_nodone", tag), 32'(obs()), 32'h0);
        end else begin
            check_val($sformatf("%s_busycnt", tag), 32'(busy_cnt),
                      (rep == 0) ? 32'd1 : 32'(rep * PAT_W + (rep - 1) * gap + 1));
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        pattern   = '0;
        rep_count = '0;
        gap_len   = '0;
        @(posedge clk);
        #1;
        check_val("reset_state", 32'(obs()), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle_after_reset", 32'(obs()), 32'h0);

        run("t1011", 4'b1011, 1, 0, -1);
        run("t1011x3g2", 4'b1011, 3, 2, -1);
        run("rep0", 4'b1111, 0, 3, -1);
        run("b2b1100", 4'b1100, 2, 0, -1);
        run("abort3rd", 4'b1011, 2, 1, 2);
        run("after_abort", 4'b0110, 2, 1, -1);
        run("maxrep", 4'b1001, 15, 7, -1);

        // Simultaneous start and abort in IDLE: nothing starts.
        start     = 1'b1;
        abort     = 1'b1;
        pattern   = 4'b1111;
        rep_count = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check_val("start_abort_idle", 32'(obs()), 32'h0);
        @(posedge clk);
        #1;
        check_val("start_abort_idle2", 32'(obs()), 32'h0);

        // Asynchronous reset landing mid-gap.
        pattern   = 4'b1011;
        rep_count = 4'd3;
        gap_len   = 3'd3;
        start     = 1'b1;
        build(4'b1011, 3, 3);
        for (int i = 0; i <= PAT_W; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            check_val($sformatf("pre_reset[%0d]", i), 32'(obs()), 32'(exp_q[i]));
        end
        #2;
        reset = 1'b1;
        #1;
        check_val("async_reset", 32'(obs()), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle_post_reset", 32'(obs()), 32'h0);
        run("post_reset_run", 4'b1010, 2, 2, -1);

        for (int k = 0; k < 25; k++) begin
            int rep;
            int gap;
            int ab;
            rep = $urandom_range(0, 6);
            gap = $urandom_range(0, 7);
            ab  = -1;
            if ($urandom_range(0, 3) == 0)
                ab = $urandom_range(0, (rep == 0) ? 0 : rep * PAT_W + (rep - 1) * gap);
            run($sformatf("rnd%0d", k), PAT_W'($urandom), rep, gap, ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
